// File: rtl/pi_cart_mapper.sv
// PI bus cartridge mapper: address latch, burst counter, window decode,
// flash strobes, status register with debounced button, boot unlock.
module pi_cart_mapper #(
    parameter int          ADDR_W       = 19,
    parameter int          BURST_W      = 13,
    parameter int          NUM_WIN      = 4,
    parameter logic [NUM_WIN*12-1:0] WIN_TAG =
        {12'h1ED, 12'h100, 12'h1EF, 12'h1EC},
    parameter logic [NUM_WIN*3-1:0]  WIN_MODE =
        {3'b001, 3'b111, 3'b010, 3'b000},
    parameter int          CE_PULSE_MAX = 8,
    parameter int          DEBOUNCE     = 20,
    parameter logic [31:0] STATUS_ADDR  = 32'h1E40_0000,
    parameter logic [31:0] UNLOCK_ADDR  = 32'h1040_0400,
    parameter logic [15:0] UNLOCK_DATA  = 16'h001E
) (
    input  logic              clk,
    input  logic              cold_reset,
    input  logic [15:0]       ad_in,
    output logic [15:0]       ad_out,
    output logic              ad_oe,
    input  logic              aleh,
    input  logic              alel,
    input  logic              read,
    input  logic              write,
    input  logic              button,
    input  logic [6:0]        status_in,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              read_top,
    output logic              boot
);

    localparam int CE_W = $clog2(CE_PULSE_MAX + 1);
    localparam int DB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } state_e;

    state_e              state_q, state_d;
    logic                rd_m_q, rd_s_q;
    logic                wr_m_q, wr_s_q;
    logic [31:0]         addr_q, addr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [CE_W-1:0]     ce_cnt_q, ce_cnt_d;
    logic [DB_W-1:0]     db_q, db_d;
    logic                press_q, press_d;
    logic                boot_q, boot_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;

    logic                rd_fall, rd_rise, wr_fall, wr_rise;
    logic                ale_any, ale_lo;
    logic                rd_entry, rd_exit, wr_entry, wr_exit;
    logic                acc, stat_sel, win_hit, map_sel;
    logic [1:0]          win_mode;
    logic                ce_ok, ce_fix_low, db_hit;
    logic [ADDR_W-1:0]   base;

    assign rd_fall = rd_s_q & ~rd_m_q;
    assign rd_rise = ~rd_s_q & rd_m_q;
    assign wr_fall = wr_s_q & ~wr_m_q;
    assign wr_rise = ~wr_s_q & wr_m_q;
    assign ale_any = aleh | alel;
    assign ale_lo  = alel & ~aleh;

    assign acc      = (state_q == S_RD) || (state_q == S_WR);
    assign stat_sel = (addr_q == STATUS_ADDR);
    assign map_sel  = win_hit & ~stat_sel;
    assign base     = addr_q[ADDR_W:1];
    assign ce_ok    = ce_cnt_q < CE_W'(CE_PULSE_MAX);
    assign db_hit   = ~button && (db_q >= DB_W'(DEBOUNCE - 1));

    assign rd_entry = (state_q != S_RD) && (state_d == S_RD);
    assign rd_exit  = (state_q == S_RD) && (state_d != S_RD);
    assign wr_entry = (state_q != S_WR) && (state_d == S_WR);
    assign wr_exit  = (state_q == S_WR) && (state_d != S_WR);

    assign flash_addr = faddr_q;
    assign boot       = boot_q;
    assign read_top   = stat_sel | win_hit;

    // Window decode: lowest-index enabled window with a matching tag wins.
    always_comb begin
        win_hit  = 1'b0;
        win_mode = 2'd0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (WIN_TAG[12*i +: 12] == addr_q[31:20] &&
                (!WIN_MODE[3*i+2] || boot_q)) begin
                win_hit  = 1'b1;
                win_mode = WIN_MODE[3*i +: 2];
            end
        end
    end

    // Access FSM next state; any ALE activity aborts the access.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rd_fall)      state_d = S_RD;
                else if (wr_fall) state_d = S_WR;
            end
            S_RD:    if (rd_rise) state_d = S_IDLE;
            S_WR:    if (wr_rise) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ale_any) state_d = S_IDLE;
    end

    // Bus and flash strobes from the selected target and access state.
    always_comb begin
        flash_ce_n = 1'b1;
        flash_oe_n = 1'b1;
        ad_out     = 16'h0000;
        ad_oe      = 1'b0;
        ce_fix_low = 1'b0;
        if (stat_sel) begin
            if (state_q == S_RD) begin
                ad_oe  = 1'b1;
                ad_out = {5'h1F, ~press_q, 3'h7, status_in};
            end
        end else if (map_sel) begin
            unique case (win_mode)
                2'd0: begin
                    if (acc) begin
                        flash_ce_n = 1'b0;
                        flash_oe_n = rd_s_q;
                    end
                end
                2'd1, 2'd2: begin
                    if (acc && ce_ok) begin
                        flash_ce_n = 1'b0;
                        flash_oe_n = rd_s_q;
                        ce_fix_low = 1'b1;
                    end
                end
                2'd3: begin
                    if (state_q == S_RD) begin
                        ad_oe  = 1'b1;
                        ad_out = 16'h0000;
                    end
                end
            endcase
        end
    end

    // Datapath next-state: address latch, counters, press, boot, write data.
    always_comb begin
        addr_d   = addr_q;
        burst_d  = burst_q;
        ce_cnt_d = ce_cnt_q;
        db_d     = db_q;
        press_d  = press_q;
        boot_d   = boot_q;
        wdata_d  = wdata_q;
        faddr_d  = faddr_q;

        if (aleh && alel) addr_d[31:16] = ad_in;
        else if (ale_lo)  addr_d[15:0]  = ad_in;

        if (ale_lo)       burst_d = '0;
        else if (rd_exit) burst_d = burst_q + BURST_W'(1);

        if (ale_lo)          ce_cnt_d = '0;
        else if (ce_fix_low) ce_cnt_d = ce_cnt_q + CE_W'(1);

        if (rd_entry) begin
            if (map_sel && win_mode == 2'd1)      faddr_d = base;
            else if (map_sel && win_mode == 2'd2) faddr_d = base + ADDR_W'(1);
            else faddr_d = base + ADDR_W'(burst_q);
        end

        if (wr_entry) wdata_d = ad_in;

        if (button)                       db_d = '0;
        else if (db_q < DB_W'(DEBOUNCE))  db_d = db_q + DB_W'(1);

        if (rd_exit && stat_sel) press_d = 1'b0;
        if (db_hit)              press_d = 1'b1;

        if (wr_exit && addr_q == UNLOCK_ADDR && wdata_q == UNLOCK_DATA)
            boot_d = 1'b0;
    end

    // State registers; strobe synchronisers idle high.
    always_ff @(posedge clk or posedge cold_reset) begin
        if (cold_reset) begin
            state_q  <= S_IDLE;
            rd_m_q   <= 1'b1;
            rd_s_q   <= 1'b1;
            wr_m_q   <= 1'b1;
            wr_s_q   <= 1'b1;
            addr_q   <= '0;
            burst_q  <= '0;
            ce_cnt_q <= '0;
            db_q     <= '0;
            press_q  <= 1'b0;
            boot_q   <= 1'b1;
            wdata_q  <= '0;
            faddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_m_q   <= read;
            rd_s_q   <= rd_m_q;
            wr_m_q   <= write;
            wr_s_q   <= wr_m_q;
            addr_q   <= addr_d;
            burst_q  <= burst_d;
            ce_cnt_q <= ce_cnt_d;
            db_q     <= db_d;
            press_q  <= press_d;
            boot_q   <= boot_d;
            wdata_q  <= wdata_d;
            faddr_q  <= faddr_d;
        end
    end

endmodule
